// File: rtl/mult8_seq_pkg.sv
// Shared types and constants for the sequential 8x8 nibble multiplier.
package mult8_seq_pkg;

    localparam int unsigned NIB_W = 4;
    localparam int unsigned OP_W  = 8;
    localparam int unsigned ACC_W = 16;

    // Left shift applied to the core product in each step
    localparam logic [3:0] SHIFT_STEP0 = 4'd0;
    localparam logic [3:0] SHIFT_STEP1 = 4'd4;
    localparam logic [3:0] SHIFT_STEP2 = 4'd4;
    localparam logic [3:0] SHIFT_STEP3 = 4'd8;

    typedef enum logic [2:0] {
        StIdle,
        StStep0,
        StStep1,
        StStep2,
        StStep3,
        StDone
    } state_e;

endpackage

// File: rtl/nibble_mul4.sv
// 4x4 -> 8 unsigned combinational multiplier core. Generated variants with the
// same a_i/b_i/p_o shape drop in here.
module nibble_mul4
    import mult8_seq_pkg::*;
(
    input  logic [NIB_W-1:0]   a_i,
    input  logic [NIB_W-1:0]   b_i,
    output logic [2*NIB_W-1:0] p_o
);

    assign p_o = (2*NIB_W)'(a_i) * (2*NIB_W)'(b_i);

endmodule

// File: rtl/mult8_seq_nibble.sv
// Sequential 8x8 unsigned multiplier: one 4x4 core reused over four steps,
// shifted products accumulated into a 16-bit result, valid/ready on both sides.
// Optional build macro MULT8_SEQ_SELFCHECK_EN adds a sticky result self-check.
module mult8_seq_nibble
    import mult8_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [OP_W-1:0]  a_i,
    input  logic [OP_W-1:0]  b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [ACC_W-1:0] p_o,
    output logic             busy_o,
    output logic             chk_err_o
);

    state_e             state_q;
    logic [OP_W-1:0]    op_a_q, op_b_q;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   p_q;
    logic               in_ready_q, out_valid_q, busy_q;

    logic [NIB_W-1:0]   nib_a, nib_b;
    logic [2*NIB_W-1:0] core_p;
    logic [3:0]         shift;

    nibble_mul4 u_core (
        .a_i (nib_a),
        .b_i (nib_b),
        .p_o (core_p)
    );

    // Pick the nibble pair and shift for the current step, form next accumulator
    always_comb begin
        nib_a = op_a_q[NIB_W-1:0];
        nib_b = op_b_q[NIB_W-1:0];
        shift = SHIFT_STEP0;
        case (state_q)
            StStep1: begin
                nib_b = op_b_q[OP_W-1:NIB_W];
                shift = SHIFT_STEP1;
            end
            StStep2: begin
                nib_a = op_a_q[OP_W-1:NIB_W];
                shift = SHIFT_STEP2;
            end
            StStep3: begin
                nib_a = op_a_q[OP_W-1:NIB_W];
                nib_b = op_b_q[OP_W-1:NIB_W];
                shift = SHIFT_STEP3;
            end
            default: ;
        endcase
        acc_d = acc_q + (ACC_W'(core_p) << shift);
    end

    // Control FSM with registered handshake outputs and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            op_a_q      <= '0;
            op_b_q      <= '0;
            acc_q       <= '0;
            p_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid_i && in_ready_q) begin
                        op_a_q     <= a_i;
                        op_b_q     <= b_i;
                        acc_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= StStep0;
                    end
                end
                StStep0: begin
                    acc_q   <= acc_d;
                    state_q <= StStep1;
                end
                StStep1: begin
                    acc_q   <= acc_d;
                    state_q <= StStep2;
                end
                StStep2: begin
                    acc_q   <= acc_d;
                    state_q <= StStep3;
                end
                StStep3: begin
                    // Final partial product goes straight into the output register
                    acc_q       <= acc_d;
                    p_q         <= acc_d;
                    out_valid_q <= 1'b1;
                    state_q     <= StDone;
                end
                StDone: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign busy_o      = busy_q;
    assign p_o         = p_q;

`ifdef MULT8_SEQ_SELFCHECK_EN
    logic             chk_err_q;
    logic [ACC_W-1:0] ref_p;

    assign ref_p = ACC_W'(op_a_q) * ACC_W'(op_b_q);

    // Sticky flag: presented result disagrees with a plain product of the operands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_err_q <= 1'b0;
        end else if (state_q == StDone && p_q != ref_p) begin
            chk_err_q <= 1'b1;
        end
    end

    assign chk_err_o = chk_err_q;
`else
    assign chk_err_o = 1'b0;
`endif

endmodule
